// File: rtl/sampler_ctrl_pkg.sv
// sampler_ctrl_pkg: shared widths, FSM state encodings and register addresses for the sampler
package sampler_ctrl_pkg;

   localparam int MSB = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam logic [7:0] NUMSAMPLESREG = 8'h04;
   localparam logic [7:0] SUBVALUEREG   = 8'h08;

endpackage

// File: rtl/sampler_outreg.sv
// sampler_outreg: single-entry valid/ready output register carrying data and last marker
module sampler_outreg
   import sampler_ctrl_pkg::*;
#(
   parameter int MSB = sampler_ctrl_pkg::MSB
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [MSB:0] load_data,
   input  logic         load_last,
   input  logic         ready,
   output logic         valid,
   output logic [MSB:0] data,
   output logic         last
);

   // load wins over drain so a same-cycle handshake and accept keep full throughput
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         last  <= 1'b0;
      end else if (clr) begin
         valid <= 1'b0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         last  <= load_last;
      end else if (ready) begin
         valid <= 1'b0;
         last  <= 1'b0;
      end
   end

endmodule

// File: rtl/sampler_ctrl.sv
// sampler_ctrl: sequences one sampling burst, subtracting a latched offset from each accepted sample
module sampler_ctrl
   import sampler_ctrl_pkg::*;
#(
   parameter int MSB = sampler_ctrl_pkg::MSB
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [MSB:0] num_samples,
   input  logic [MSB:0] sub_value,
   input  logic         in_valid,
   input  logic [MSB:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [MSB:0] out_data,
   output logic         out_last,
   input  logic         out_ready,
   output logic         busy,
   output logic         done,
   output logic [MSB:0] sample_cnt
);

   state_t       state;
   logic [MSB:0] tgt;
   logic [MSB:0] off;
   logic         accept;
   logic         is_last;

   assign in_ready = (state == RUN) && !abort && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign is_last  = (sample_cnt == tgt - 1'b1);

   sampler_outreg #(.MSB(MSB)) u_outreg (
      .clk       (clk),
      .rst       (rst),
      .clr       (abort),
      .load      (accept),
      .load_data (in_data - off),
      .load_last (is_last),
      .ready     (out_ready),
      .valid     (out_valid),
      .data      (out_data),
      .last      (out_last)
   );

   // burst sequencing: config latch, sample counting, completion pulse; abort overrides everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         sample_cnt <= '0;
         tgt        <= '0;
         off        <= '0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  tgt        <= num_samples;
                  off        <= sub_value;
                  sample_cnt <= '0;
                  busy       <= 1'b1;
                  state      <= ARM;
               end
               ARM: if (tgt == '0) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  state <= RUN;
               end
               RUN: if (accept) begin
                  sample_cnt <= sample_cnt + 1'b1;
                  if (is_last) state <= DRAIN;
               end
               DRAIN: if (out_valid && out_ready && out_last) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sampler_ctrl.sv
// tb_sampler_ctrl: directed self-checking bench for sampler_ctrl
module tb_sampler_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] num_samples = '0;
   logic [15:0] sub_value = '0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_last;
   logic        out_ready = 1'b0;
   logic        busy;
   logic        done;
   logic [15:0] sample_cnt;

   int checks = 0;
   int failures = 0;

   sampler_ctrl #(.MSB(15)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .num_samples (num_samples),
      .sub_value   (sub_value),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_last    (out_last),
      .out_ready   (out_ready),
      .busy        (busy),
      .done        (done),
      .sample_cnt  (sample_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_cnt", sample_cnt, 0);
      check("rst_data", out_data, 0);
      check("rst_last", out_last, 0);
      step();
      step();
      rst = 1'b0;
      step();

      // basic burst
      num_samples = 16'd4; sub_value = 16'd10; start = 1'b1;
      step();
      start = 1'b0; in_valid = 1'b1; in_data = 16'd100; out_ready = 1'b1;
      check("b_arm_busy", busy, 1);
      check("b_arm_in_ready", in_ready, 0);
      step();
      check("b_run_in_ready", in_ready, 1);
      check("b_run_out_valid", out_valid, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("b_valid", out_valid, 1);
         check("b_data", out_data, 90 + i);
         check("b_last", out_last, (i == 3) ? 1 : 0);
         check("b_cnt", sample_cnt, i + 1);
         in_data = 16'(101 + i);
      end
      in_valid = 1'b0;
      check("b_drain_in_ready", in_ready, 0);
      check("b_drain_done", done, 0);
      step();
      check("b_end_valid", out_valid, 0);
      check("b_done", done, 1);
      check("b_end_busy", busy, 0);
      step();
      check("b_done_pulse", done, 0);
      check("b_cnt_hold", sample_cnt, 4);

      // zero-length burst
      num_samples = 16'd0; start = 1'b1;
      step();
      start = 1'b0;
      check("z_busy", busy, 1);
      check("z_done_early", done, 0);
      step();
      check("z_done", done, 1);
      check("z_busy_low", busy, 0);
      check("z_valid", out_valid, 0);
      check("z_cnt", sample_cnt, 0);
      step();
      check("z_done_pulse", done, 0);
      check("z_valid2", out_valid, 0);

      // backpressure
      num_samples = 16'd3; sub_value = 16'd10; start = 1'b1;
      step();
      start = 1'b0; in_valid = 1'b1; in_data = 16'd100; out_ready = 1'b1;
      step();
      step();
      check("p_first", out_data, 90);
      out_ready = 1'b0; in_data = 16'd101;
      #1;
      check("p_stall_in_ready", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("p_hold_valid", out_valid, 1);
         check("p_hold_data", out_data, 90);
         check("p_hold_cnt", sample_cnt, 1);
         check("p_hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      #1;
      check("p_resume_in_ready", in_ready, 1);
      step();
      check("p_second", out_data, 91);
      check("p_second_cnt", sample_cnt, 2);
      in_data = 16'd102;
      step();
      check("p_third", out_data, 92);
      check("p_third_last", out_last, 1);
      check("p_third_cnt", sample_cnt, 3);
      in_valid = 1'b0;
      step();
      check("p_done", done, 1);
      check("p_end_valid", out_valid, 0);

      // wrap arithmetic
      num_samples = 16'd1; sub_value = 16'd5; start = 1'b1;
      step();
      start = 1'b0; in_valid = 1'b1; in_data = 16'd2;
      step();
      step();
      check("w_data", out_data, 16'hFFFD);
      check("w_last", out_last, 1);
      in_valid = 1'b0;
      step();
      check("w_done", done, 1);

      // abort after 2 of 8
      num_samples = 16'd8; sub_value = 16'd0; start = 1'b1;
      step();
      start = 1'b0; in_valid = 1'b1; in_data = 16'd7;
      step();
      step();
      check("a_cnt1", sample_cnt, 1);
      step();
      check("a_cnt2", sample_cnt, 2);
      in_valid = 1'b0; abort = 1'b1;
      step();
      abort = 1'b0;
      check("a_valid", out_valid, 0);
      check("a_busy", busy, 0);
      check("a_done", done, 0);
      check("a_cnt", sample_cnt, 2);
      step();
      check("a_done_late", done, 0);
      check("a_in_ready", in_ready, 0);

      // abort beats start
      start = 1'b1; abort = 1'b1; num_samples = 16'd2;
      step();
      start = 1'b0; abort = 1'b0;
      check("as_busy", busy, 0);
      check("as_cnt", sample_cnt, 2);

      // config change mid-burst is ignored
      num_samples = 16'd4; sub_value = 16'd0; start = 1'b1;
      step();
      start = 1'b0; num_samples = 16'd2; sub_value = 16'd1; in_valid = 1'b1; in_data = 16'd20;
      step();
      for (int i = 0; i < 4; i++) begin
         step();
         check("c_valid", out_valid, 1);
         check("c_data", out_data, 20 + i);
         check("c_last", out_last, (i == 3) ? 1 : 0);
         in_data = 16'(21 + i);
      end
      in_valid = 1'b0;
      step();
      check("c_done", done, 1);
      check("c_cnt", sample_cnt, 4);

      // async reset mid-burst
      num_samples = 16'd4; sub_value = 16'd10; start = 1'b1;
      step();
      start = 1'b0; in_valid = 1'b1; in_data = 16'd100;
      step();
      step();
      check("r_valid_before", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("r_valid", out_valid, 0);
      check("r_data", out_data, 0);
      check("r_busy", busy, 0);
      check("r_cnt", sample_cnt, 0);
      check("r_in_ready", in_ready, 0);
      in_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
      num_samples = 16'd1; sub_value = 16'd10; start = 1'b1;
      step();
      start = 1'b0; in_valid = 1'b1; in_data = 16'd50;
      step();
      step();
      check("r2_data", out_data, 40);
      check("r2_last", out_last, 1);
      in_valid = 1'b0;
      step();
      check("r2_done", done, 1);
      check("r2_cnt", sample_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
